bit_serializer_tx: RTL and testbench
====================================

Name: bit_serializer_tx

Overview:
- Upstream feeder for the serial sequence-detector FSMs.
- Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per enabled clock on dout. dout drives a detector's din directly.
- One-word holding buffer, so back-to-back words stream with no bubble between them.
- bit_en paces the output: the stream advances only on cycles where bit_en=1.

Parameters:
- WIDTH, 8: word width in bits; must be ≥2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: value driven on dout whenever dout_valid=0.

Ports:
- clk  input  1  single system clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; transfer occurs when in_valid & in_ready at a clock edge.
- bit_en  input  1  advance/stall: the current bit is consumed on a clock edge only when bit_en=1.
- dout  output  1  current serial bit.
- dout_valid  output  1  dout carries a real data bit.
- word_done  output  1  combinational pulse; high on the cycle the last bit of a word is consumed.
- busy  output  1  shifter or holding buffer is occupied.

Behaviour:
- Reset state:
  - States are IDLE and SHIFT; IDLE on reset.
  - shifter cleared, bit count=0, hold_valid=0.
  - in_ready=1, dout=IDLE_BIT, dout_valid=0, word_done=0, busy=0.
  - Reset overrides all other events, including an accept or a consume in the same cycle. A partially sent word and any held word are discarded.
- Storage:
  - shifter: WIDTH-bit register, plus bit counter of width clog2(WIDTH).
  - hold: WIDTH-bit register with hold_valid flag.
- Output decode:
  - dout_valid = (state==SHIFT).
  - dout = current shifter bit (MSB or LSB per MSB_FIRST) in SHIFT; IDLE_BIT otherwise.
  - in_ready = !hold_valid, registered-state derived only; never depends on in_valid.
  - busy = (state==SHIFT) | hold_valid.
- consume = SHIFT & bit_en.
  - On consume: shifter shifts by one toward the output end; count increments.
  - last = consume & (count==WIDTH-1); word_done = last.
- IDLE transitions:
  - accept: load in_data into shifter, count=0, go to SHIFT. The first bit appears on dout the cycle after the accept edge.
  - No accept: stay in IDLE.
- SHIFT with last:
  - hold_valid=1: load hold into shifter, count=0, clear hold_valid, stay in SHIFT. No gap: dout_valid stays 1.
  - hold_valid=0 and accept: load in_data into shifter directly, stay in SHIFT. No gap.
  - hold_valid=0 and no accept: go to IDLE.
- SHIFT without last:
  - An accept writes in_data into hold and sets hold_valid.
- Accept cannot collide with a hold reload, because in_ready=0 whenever hold_valid=1.
- Throughput and latency:
  - Sustained throughput is 1 bit/cycle with bit_en held high.
  - Accept-to-first-bit latency is 1 cycle when idle.
- bit_en=0 stalls:
  - dout, dout_valid, count and shifter all hold.
  - Accepts into hold still occur if in_ready=1.
- in_data is sampled only at the accept edge; later changes have no effect on the stored word.

Test Plan:
- Single word, MSB_FIRST=1, in_data=8'b1001_0000 accepted at cycle 0, bit_en=1 → dout=1,0,0,1,0,0,0,0 on cycles 1–8; dout_valid=1 on cycles 1–8 only; word_done high on cycle 8. Feeding dout into a 10010 detector produces exactly one detection.
- Back-to-back 8'hA5 then 8'h3C, second accepted while the first is shifting → 16 contiguous bits 10100101 00111100; dout_valid never drops; word_done on cycles 8 and 16.
- Stall: 8'hA5 with bit_en low on cycles 3–5 → dout holds its bit-3 value through the stall; word_done delayed to cycle 11; total of 8 consumed bits.
- Backpressure: with hold full, in_ready=0. Hold in_valid=1 with a third word → not accepted until the cycle after the first word's last bit; no word is lost or duplicated.
- MSB_FIRST=0, in_data=8'h01 → dout=1,0,0,0,0,0,0,0.
- Reset asserted at cycle 4 of a word with hold full → next cycle: dout_valid=0, busy=0, in_ready=1, dout=IDLE_BIT. A new word afterwards serializes correctly from its first bit.

Source files
------------

// File: rtl/bit_serializer_tx.sv
// Word-to-bit serializer with a one-word holding buffer; streams WIDTH-bit words
// onto dout one bit per bit_en cycle, with no bubble between back-to-back words.
module bit_serializer_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shifter_r, shifter_s;
  logic [WIDTH-1:0] hold_r, hold_s;
  logic [CW-1:0]    count_r, count_s;
  logic             hold_valid_r, hold_valid_s;
  logic             accept_s, consume_s, last_s, out_bit_s;
  logic [WIDTH-1:0] shifted_s;

  // in_ready comes only from registered state so it never loops back through in_valid
  assign in_ready   = ~hold_valid_r;
  assign accept_s   = in_valid & ~hold_valid_r;
  assign consume_s  = (state_r == SHIFT) & bit_en;
  assign last_s     = consume_s & (count_r == LAST_CNT);
  assign out_bit_s  = MSB_FIRST ? shifter_r[WIDTH-1] : shifter_r[0];
  assign shifted_s  = MSB_FIRST ? {shifter_r[WIDTH-2:0], 1'b0} : {1'b0, shifter_r[WIDTH-1:1]};

  assign dout_valid = (state_r == SHIFT);
  assign dout       = (state_r == SHIFT) ? out_bit_s : IDLE_BIT;
  assign word_done  = last_s;
  assign busy       = (state_r == SHIFT) | hold_valid_r;

  // Next-state, shifter, counter and holding-buffer update rules
  always_comb begin
    state_s      = state_r;
    shifter_s    = shifter_r;
    count_s      = count_r;
    hold_s       = hold_r;
    hold_valid_s = hold_valid_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shifter_s = in_data;
          count_s   = CNT_ZERO;
          state_s   = SHIFT;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          // Word boundary: reload from hold first, then from the port, else go idle
          if (hold_valid_r) begin
            shifter_s    = hold_r;
            count_s      = CNT_ZERO;
            hold_valid_s = 1'b0;
          end else if (accept_s) begin
            shifter_s    = in_data;
            count_s      = CNT_ZERO;
          end else begin
            shifter_s    = shifted_s;
            count_s      = CNT_ZERO;
            state_s      = IDLE;
          end
        end else begin
          if (consume_s) begin
            shifter_s = shifted_s;
            count_s   = count_r + CNT_ONE;
          end else begin
            shifter_s = shifter_r;
          end
          if (accept_s) begin
            hold_s       = in_data;
            hold_valid_s = 1'b1;
          end else begin
            hold_valid_s = hold_valid_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that discards any in-flight or held word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      shifter_r    <= {WIDTH{1'b0}};
      hold_r       <= {WIDTH{1'b0}};
      count_r      <= CNT_ZERO;
      hold_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shifter_r    <= shifter_s;
      hold_r       <= hold_s;
      count_r      <= count_s;
      hold_valid_r <= hold_valid_s;
    end
  end

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Scoreboard bench for bit_serializer_tx: an MSB-first and an LSB-first instance share
// stimulus and are checked against a queue-of-words reference model.
module tb_bit_serializer_tx;

  logic       clk = 1'b0;
  logic       reset, in_valid, bit_en;
  logic [7:0] in_data;
  logic       rdy_m, dout_m, dv_m, wd_m, busy_m;
  logic       rdy_l, dout_l, dv_l, wd_l, busy_l;

  int tests = 0;
  int fails = 0;

  // Reference model: words accepted but not fully sent, and bits consumed of the head word
  logic [7:0] exp_q[$];
  int         cnt = 0;
  int         det = 0;
  logic [4:0] hist = 5'b0;
  logic       exp_ready = 1'b1;

  bit_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .bit_en(bit_en), .dout(dout_m), .dout_valid(dv_m), .word_done(wd_m), .busy(busy_m)
  );

  bit_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .bit_en(bit_en), .dout(dout_l), .dout_valid(dv_l), .word_done(wd_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and keep it offered until the handshake completes (bounded)
  task automatic send(input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (rdy_m) ok = 1'b1;
      cyc();
    end
    chk("send_accept", {31'b0, ok}, 32'd1);
  endtask

  // Monitor (negedge: compare and consume) and input-side scoreboard push (posedge)
  always begin
    logic       ev;
    logic [7:0] w;
    @(negedge clk);
    ev        = (exp_q.size() > 0);
    exp_ready = (exp_q.size() < 2);
    chk("dout_valid_msb", {31'b0, dv_m}, {31'b0, ev});
    chk("dout_valid_lsb", {31'b0, dv_l}, {31'b0, ev});
    chk("in_ready_msb", {31'b0, rdy_m}, {31'b0, exp_ready});
    chk("in_ready_lsb", {31'b0, rdy_l}, {31'b0, exp_ready});
    chk("busy_msb", {31'b0, busy_m}, {31'b0, ev});
    chk("busy_lsb", {31'b0, busy_l}, {31'b0, ev});
    if (ev) begin
      w = exp_q[0];
      chk("dout_msb", {31'b0, dout_m}, {31'b0, w[7-cnt]});
      chk("dout_lsb", {31'b0, dout_l}, {31'b0, w[cnt]});
      chk("word_done_msb", {31'b0, wd_m}, {31'b0, (bit_en && cnt == 7)});
      chk("word_done_lsb", {31'b0, wd_l}, {31'b0, (bit_en && cnt == 7)});
      if (bit_en) begin
        hist = {hist[3:0], w[7-cnt]};
        if (hist == 5'b10010) det++;
        cnt++;
        if (cnt == 8) begin
          void'(exp_q.pop_front());
          cnt = 0;
        end
      end
    end else begin
      chk("idle_dout_msb", {31'b0, dout_m}, 32'd0);
      chk("idle_dout_lsb", {31'b0, dout_l}, 32'd1);
      chk("idle_done_msb", {31'b0, wd_m}, 32'd0);
      chk("idle_done_lsb", {31'b0, wd_l}, 32'd0);
    end
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      cnt  = 0;
      hist = 5'b0;
    end else if (in_valid && exp_ready) begin
      exp_q.push_back(in_data);
    end
  end

  initial begin
    int det_base;
    reset = 1'b1; in_valid = 1'b0; bit_en = 1'b0; in_data = 8'h00;
    repeat (2) cyc();
    chk("reset_ready", {31'b0, rdy_m}, 32'd1);
    chk("reset_valid", {31'b0, dv_m}, 32'd0);
    reset = 1'b0;
    cyc();

    // Single word into a 10010 detector
    det_base = det;
    bit_en = 1'b1;
    send(8'h90);
    in_valid = 1'b0;
    repeat (10) cyc();
    chk("detect_10010", det - det_base, 32'd1);

    // Back-to-back words, second lands in hold while the first is shifting
    in_data = 8'hA5; in_valid = 1'b1; cyc();
    in_data = 8'h3C; cyc();
    in_valid = 1'b0; in_data = 8'hFF;
    repeat (18) cyc();

    // Stall on cycles 3-5 after accept
    send(8'hA5);
    in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      bit_en = !(c >= 3 && c <= 5);
      cyc();
    end
    bit_en = 1'b1;

    // Backpressure: third word waits for the hold to drain
    send(8'h11); send(8'h22); send(8'h33);
    in_valid = 1'b0;
    repeat (30) cyc();

    send(8'h01);
    in_valid = 1'b0;
    repeat (10) cyc();

    // Reset mid-word with hold full
    send(8'hC3); send(8'h5A);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("pre_reset_hold_full", {31'b0, rdy_m}, 32'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("post_reset_busy", {31'b0, busy_m}, 32'd0);
    chk("post_reset_ready", {31'b0, rdy_m}, 32'd1);
    chk("post_reset_dout", {31'b0, dout_m}, 32'd0);
    send(8'h96);
    in_valid = 1'b0;
    repeat (10) cyc();

    // Randomized traffic with random pacing and changing in_data
    repeat (1500) begin
      bit_en   = ($urandom_range(0, 3) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    bit_en   = 1'b1;
    repeat (30) cyc();
    chk("drained_busy", {31'b0, busy_m}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
